// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings, step count and sign helper for the iterative divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_e;

    localparam int DIV_STEPS = 32;

    // Two's-complement negate when c is set; -0x80000000 wraps to itself.
    function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
        return c ? -v : v;
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: applies DIV sign rules and the divide-by-zero quotient to magnitude results.
// Ports: mag_q/mag_r magnitude quotient/remainder; neg_q/neg_r negate flags; is_signed DIV vs DIVU;
//        div_zero divisor was zero; hi/lo final remainder/quotient.
module div_sign_fix
    import div_unit_pkg::*;
(
    input  logic [31:0] mag_q,
    input  logic [31:0] mag_r,
    input  logic        neg_q,
    input  logic        neg_r,
    input  logic        is_signed,
    input  logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // With a zero divisor the remainder path already yields |dividend|, and re-applying the
    // dividend sign restores the raw dividend, so only the quotient needs overriding.
    always_comb begin
        lo = div_zero ? '1 : neg_if(is_signed & neg_q, mag_q);
        hi = neg_if(is_signed & neg_r, mag_r);
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider (DIV/DIVU), 33 busy cycles per operation.
// Ports: clock/reset (async active-high); start/is_signed/dividend/divisor request a divide;
//        busy while running; done pulses one cycle as div_hi (remainder)/div_lo (quotient) update.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] div_hi,
    output logic [31:0] div_lo
);

    div_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_q_q, neg_q_d;
    logic        neg_r_q, neg_r_d;
    logic        signed_q, signed_d;
    logic        dvz_q, dvz_d;
    logic        done_q, done_d;
    logic [31:0] div_hi_q, div_hi_d;
    logic [31:0] div_lo_q, div_lo_d;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] fix_hi, fix_lo;

    div_sign_fix u_sign_fix (
        .mag_q     (quo_q),
        .mag_r     (rem_q),
        .neg_q     (neg_q_q),
        .neg_r     (neg_r_q),
        .is_signed (signed_q),
        .div_zero  (dvz_q),
        .hi        (fix_hi),
        .lo        (fix_lo)
    );

    // The quotient register doubles as the dividend shifter: its MSB feeds the remainder
    // while each new quotient bit enters at the bottom. The stored remainder is always
    // below the divisor, so 32 bits suffice; the shifted trial value needs 33.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        signed_d = signed_q;
        dvz_d    = dvz_q;
        done_d   = 1'b0;
        div_hi_d = div_hi_q;
        div_lo_d = div_lo_q;
        trial    = {rem_q, quo_q[31]};
        ge       = trial >= {1'b0, dvs_q};
        case (state_q)
            DIV_IDLE: if (start) begin
                state_d  = DIV_RUN;
                count_d  = '0;
                rem_d    = '0;
                quo_d    = neg_if(is_signed & dividend[31], dividend);
                dvs_d    = neg_if(is_signed & divisor[31], divisor);
                neg_q_d  = is_signed & (dividend[31] ^ divisor[31]);
                neg_r_d  = is_signed & dividend[31];
                signed_d = is_signed;
                dvz_d    = divisor == '0;
            end
            DIV_RUN: begin
                rem_d   = ge ? 32'(trial - {1'b0, dvs_q}) : trial[31:0];
                quo_d   = {quo_q[30:0], ge};
                count_d = count_q + 5'd1;
                state_d = count_q == 5'(DIV_STEPS - 1) ? DIV_FIX : DIV_RUN;
            end
            DIV_FIX: begin
                div_hi_d = fix_hi;
                div_lo_d = fix_lo;
                done_d   = 1'b1;
                state_d  = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= DIV_IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            signed_q <= 1'b0;
            dvz_q    <= 1'b0;
            done_q   <= 1'b0;
            div_hi_q <= '0;
            div_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            signed_q <= signed_d;
            dvz_q    <= dvz_d;
            done_q   <= done_d;
            div_hi_q <= div_hi_d;
            div_lo_q <= div_lo_d;
        end
    end

    assign busy   = state_q != DIV_IDLE;
    assign done   = done_q;
    assign div_hi = div_hi_q;
    assign div_lo = div_lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done;
    logic [31:0] div_hi, div_lo;

    int checks = 0;
    int failures = 0;
    int n, bc, done_seen;

    div_unit dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_hi    (div_hi),
        .div_lo    (div_lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a request and let edge N sample it; returns 1 ns after edge N with n=bc=0.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        bc = 0;
    endtask

    // Step edges until done (bounded), counting busy samples, then check latency and results.
    task automatic finish_div(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        while (!done && n < 40) begin
            if (busy) bc++;
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_latency"}, n, 33);
        check({tag, "_busy_cycles"}, bc, 33);
        check({tag, "_busy_after"}, {31'd0, busy}, 0);
        check({tag, "_lo"}, div_lo, exp_lo);
        check({tag, "_hi"}, div_hi, exp_hi);
    endtask

    initial begin
        #2;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_hi", div_hi, 0);
        check("reset_lo", div_lo, 0);
        @(negedge clock);
        reset = 1'b0;

        @(negedge clock);
        issue(1'b0, 32'd100, 32'd7);
        finish_div("u100_7", 32'd14, 32'd2);
        @(posedge clock);
        #1;
        check("done_width", {31'd0, done}, 0);
        check("hold_lo", div_lo, 32'd14);

        @(negedge clock);
        issue(1'b1, 32'hFFFFFF9C, 32'd7);
        finish_div("sm100_7", 32'hFFFFFFF2, 32'hFFFFFFFE);

        @(negedge clock);
        issue(1'b1, 32'd100, 32'hFFFFFFF9);
        finish_div("s100_m7", 32'hFFFFFFF2, 32'd2);

        @(negedge clock);
        issue(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE);
        finish_div("sm7_m2", 32'd3, 32'hFFFFFFFF);

        @(negedge clock);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
        finish_div("ovf", 32'h80000000, 32'd0);

        @(negedge clock);
        issue(1'b0, 32'h12345678, 32'd0);
        finish_div("udz", 32'hFFFFFFFF, 32'h12345678);

        @(negedge clock);
        issue(1'b1, 32'hFFFFFF9C, 32'd0);
        finish_div("sdz", 32'hFFFFFFFF, 32'hFFFFFF9C);

        // Start on the done cycle: the new request goes straight in.
        issue(1'b0, 32'hFFFFFFFF, 32'h10);
        finish_div("b2b", 32'h0FFFFFFF, 32'hF);

        // A start mid-RUN must be ignored.
        @(negedge clock);
        issue(1'b1, 32'd1000, 32'd3);
        repeat (10) begin
            if (busy) bc++;
            @(posedge clock);
            #1;
            n++;
        end
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd5;
        divisor = 32'd5;
        if (busy) bc++;
        @(posedge clock);
        #1;
        n++;
        start = 1'b0;
        check("ign_hold_lo", div_lo, 32'h0FFFFFFF);
        finish_div("ign", 32'd333, 32'd1);
        @(posedge clock);
        #1;
        check("ign_no_restart", {31'd0, busy}, 0);

        // Asynchronous reset between edges N+10 and N+11.
        @(negedge clock);
        issue(1'b0, 32'd77, 32'd5);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_hi", div_hi, 0);
        check("rst_lo", div_lo, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        reset = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);

        @(negedge clock);
        issue(1'b0, 32'd7, 32'd100);
        finish_div("post_rst", 32'd0, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
